wb_merge_arbiter: RTL
=====================

// Module: wb_merge_arbiter
// PURPOSE
//  Parametrised write-back merger for the GRF single write port. The in-order W-stage result
//  (pipe_*) always owns the port. NCH out-of-order producers (MD unit, late CP0/DM returns)
//  deliver through valid/ready into a shared DEPTH-entry FIFO. The FIFO drains on cycles where
//  the pipeline does not write. A per-register busy query lets HCU stall on pending writes.
// PARAMETERS
//  DATA_W  32  write-data width
//  ADDR_W  5   register-address width
//  NCH     2   number of side-channel producers (>=1)
//  DEPTH   4   side FIFO entries (power of two, >=2)
// PORTS
//  clk          in   1             clock, rising edge
//  reset        in   1             asynchronous, active-low; clears all state
//  pipe_we      in   1             W-stage write enable
//  pipe_a3      in   ADDR_W        W-stage destination
//  pipe_wd      in   DATA_W        W-stage data
//  ch_valid     in   NCH           side-channel request, bit i = channel i
//  ch_a3        in   NCH*ADDR_W    side destinations, channel i at [i*ADDR_W +: ADDR_W]
//  ch_wd        in   NCH*DATA_W    side data, channel i at [i*DATA_W +: DATA_W]
//  ch_ready     out  NCH           one-hot accept for this cycle
//  grf_we       out  1             GRF write enable
//  grf_a3       out  ADDR_W        GRF write address
//  grf_wd       out  DATA_W        GRF write data, also the forwarding value
//  grf_src      out  1             0 = pipeline, 1 = FIFO head
//  q_rs, q_rt   in   ADDR_W        busy-query addresses from HCU
//  q_rs_busy    out  1             q_rs is pending in the FIFO
//  q_rt_busy    out  1             q_rt is pending in the FIFO
//  fifo_count   out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (reset==0, async): FIFO empty, rd/wr pointers 0, rr pointer 0, fifo_count 0.
//   With pipe_we=0 and ch_valid=0, every output is 0.
//  pipe_hit = pipe_we & (pipe_a3!=0). pop = ~pipe_hit & (fifo_count!=0).
//  Write port, combinational, zero latency:
//   - pipe_hit: grf_we=1, grf_a3=pipe_a3, grf_wd=pipe_wd, grf_src=0.
//   - pop: grf_we=1, grf_a3/grf_wd from the FIFO head, grf_src=1.
//   - neither: grf_we=0, grf_a3=0, grf_wd=0, grf_src=0.
//   - A pipe write to $0 is dropped and does not block a pop.
//  Accept:
//   - Round-robin from the rr pointer over the valid channels. The first valid channel at or
//     after rr is granted.
//   - ch_ready[g]=1 only if fifo_count<DEPTH. There is no full-bypass, even when a pop occurs
//     in the same cycle.
//   - Accepted entry with a3!=0 is pushed at the clock edge. Entry with a3==0 is accepted
//     and discarded.
//   - rr <= g+1 (mod NCH), only on an accepted transfer. Otherwise rr holds.
//   - Channels must hold valid/a3/wd stable until ready. The block does not check this.
//  Counter: push only gives +1, pop only gives -1, push and pop together leave the count
//   unchanged. Pointers wrap mod DEPTH.
//  Busy (combinational from stored entries only):
//   - q_x_busy=1 iff q_x!=0 and any occupied entry has a3==q_x.
//   - A same-cycle incoming channel does not set busy.
//   - The entry being popped this cycle still reports busy. grf_wd forwards the value.
//  Ordering:
//   - FIFO drains in acceptance order.
//   - HCU must stall any instruction whose source or destination is busy, so RAW and WAW
//     stay correct.
//   - This block does not reorder pipeline writes against FIFO writes.
//  Reset mid-operation: all pending entries are lost immediately, and ready falls
//   asynchronously.
// TESTING
//  1. Reset, then ch_valid=01, a3=8, wd=0x1234, pipe_we=0 -> ready=01.
//     Next cycle: grf_we=1, a3=8, wd=0x1234, src=1. Count goes 1 then 0.
//  2. Both channels valid every cycle (a3=9/10), pipe_we=1 with a3=3 -> grants alternate
//     01,10,01,10 and stop when fifo_count=4. grf_src stays 0. With pipe_we=0 the FIFO
//     drains 4 writes in grant order.
//  3. FIFO full, one pop and channel 1 valid in the same cycle -> ready=0 that cycle.
//     Accepted next cycle, count 3 then 4.
//  4. Channel 0 with a3=0 -> ready=1, count unchanged, grf_we never from the FIFO.
//     pipe_we=1 with pipe_a3=0 while the FIFO holds 1 entry -> that entry pops that cycle.
//  5. FIFO holds a3=12. q_rs=12 -> busy=1. q_rt=0 -> busy=0. Busy clears the cycle after
//     the pop edge.
//  6. FIFO holds 3 entries, reset pulsed low mid-cycle -> count=0, ready=0, grf_we=0
//     immediately, no stale write after release.

Source files
------------

// File: rtl/wb_merge_arbiter.sv
// Write-back merger for the single GRF write port: the in-order pipeline write wins,
// side-channel producers queue in a shared FIFO that drains on idle write cycles.
module wb_merge_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NCH    = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_we,
    input  logic [ADDR_W-1:0]        pipe_a3,
    input  logic [DATA_W-1:0]        pipe_wd,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [NCH*ADDR_W-1:0]    ch_a3,
    input  logic [NCH*DATA_W-1:0]    ch_wd,
    output logic [NCH-1:0]           ch_ready,
    output logic                     grf_we,
    output logic [ADDR_W-1:0]        grf_a3,
    output logic [DATA_W-1:0]        grf_wd,
    output logic                     grf_src,
    input  logic [ADDR_W-1:0]        q_rs,
    input  logic [ADDR_W-1:0]        q_rt,
    output logic                     q_rs_busy,
    output logic                     q_rt_busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [ADDR_W-1:0] mem_a3 [DEPTH];
    logic [DATA_W-1:0] mem_wd [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [RR_W-1:0]   rr;

    logic              grant_hit;
    logic [RR_W-1:0]   grant_idx;
    logic              full;
    logic              accept;
    logic              push;
    logic              pipe_hit;
    logic              pop;
    logic [ADDR_W-1:0] sel_a3;
    logic [DATA_W-1:0] sel_wd;

    // Round-robin search: first valid channel at or after rr.
    always_comb begin : grant_search
        int idx;
        idx       = 0;
        grant_hit = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!grant_hit && ch_valid[idx]) begin
                grant_hit = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
    end

    assign full = (count == CNT_W'(DEPTH));

    // Ready is gated by reset so it drops the moment reset asserts.
    always_comb begin
        ch_ready = '0;
        if (reset && grant_hit && !full) begin
            ch_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |ch_ready;
    assign sel_a3 = ch_a3[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_wd = ch_wd[int'(grant_idx)*DATA_W +: DATA_W];
    // Writes to $0 are accepted but never stored.
    assign push   = accept && (sel_a3 != '0);

    assign pipe_hit = pipe_we && (pipe_a3 != '0);
    assign pop      = !pipe_hit && (count != '0);

    always_comb begin
        grf_we  = 1'b0;
        grf_a3  = '0;
        grf_wd  = '0;
        grf_src = 1'b0;
        if (pipe_hit) begin
            grf_we = 1'b1;
            grf_a3 = pipe_a3;
            grf_wd = pipe_wd;
        end else if (pop) begin
            grf_we  = 1'b1;
            grf_a3  = mem_a3[rd_ptr];
            grf_wd  = mem_wd[rd_ptr];
            grf_src = 1'b1;
        end
    end

    // An entry is occupied when its distance from the head is below the count.
    always_comb begin : busy_scan
        logic [PTR_W-1:0] offset;
        logic             occupied;
        offset    = '0;
        occupied  = 1'b0;
        q_rs_busy = 1'b0;
        q_rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PTR_W'(i) - rd_ptr;
            occupied = ({1'b0, offset} < count);
            if (occupied && (q_rs != '0) && (mem_a3[i] == q_rs)) begin
                q_rs_busy = 1'b1;
            end
            if (occupied && (q_rt != '0) && (mem_a3[i] == q_rt)) begin
                q_rt_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rr     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (accept) begin
                rr <= (grant_idx == RR_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a3[wr_ptr] <= sel_a3;
            mem_wd[wr_ptr] <= sel_wd;
        end
    end

    assign fifo_count = count;

endmodule
